clawgame_proc: RTL and testbench

- Score-keeping and display core of the claw game.
- Counts rising edges on an asynchronous `increment_score` input and holds the score as an 8-digit BCD value.
- Time-multiplexes the score onto an 8-digit common-anode seven-segment display.
- Sits between the game-event logic and the board display pins.

---
 rtl/clawgame_pkg.sv | 37 +++
 rtl/seven_seg_mux.sv | 39 +++
 rtl/clawgame_proc.sv | 79 +++++++
 tb/tb_clawgame_proc.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/clawgame_pkg.sv
// Shared constants and helpers for the claw game score/display core.
// Segment codes are 7-bit gfedcba with each bit low when that segment is lit.
package clawgame_pkg;

   localparam int REFRESH_LOG2_DEFAULT = 2;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seven_seg_mux.sv
// Scans an 8-digit BCD value onto a common-anode display, one digit per
// 2^REFRESH_LOG2 cycles, digit 0 (units) first.
module seven_seg_mux
   import clawgame_pkg::*;
#(
   parameter int REFRESH_LOG2 = REFRESH_LOG2_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] score,
   output logic [7:0]  anode_activate,
   output logic [7:0]  LED_out
);

   localparam int CNT_W = REFRESH_LOG2 + 3;

   logic [CNT_W-1:0] refresh_cnt_r;
   logic [2:0]       sel_s;
   logic [3:0]       digit_s;

   // Free-running refresh counter; its top three bits pick the lit digit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         refresh_cnt_r <= '0;
      end else begin
         refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
      end
   end

   assign sel_s   = refresh_cnt_r[CNT_W-1 -: 3];
   assign digit_s = score[{sel_s, 2'b00} +: 4];

   // Decoded straight from registered state so a new digit or score shows the same cycle.
   always_comb begin
      anode_activate = ~(8'h01 << sel_s);
      LED_out        = {1'b1, bcd_to_seg(digit_s)};
   end

endmodule

// File: rtl/clawgame_proc.sv
// Claw game score core: synchronizes the score event input, counts its rising
// edges as an 8-digit BCD score and drives the multiplexed seven-segment display.
module clawgame_proc
   import clawgame_pkg::*;
#(
   parameter int REFRESH_LOG2 = REFRESH_LOG2_DEFAULT,
   parameter int NUM_DIGITS   = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       increment_score,
   output logic [7:0] anode_activate,
   output logic [7:0] LED_out
);

   localparam int SCORE_W = 4 * NUM_DIGITS;

   logic               s1_r;
   logic               s2_r;
   logic               prev_r;
   logic               inc_pulse_s;
   logic [SCORE_W-1:0] score_r;
   logic [SCORE_W-1:0] score_next_s;
   logic               carry_s;

   // Two-flop synchronizer plus the previous-sample flop for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         prev_r <= 1'b0;
      end else begin
         s1_r   <= increment_score;
         s2_r   <= s1_r;
         prev_r <= s2_r;
      end
   end

   assign inc_pulse_s = s2_r & ~prev_r;

   // Decimal ripple increment: a 9 rolls to 0 and carries on; the top digit's carry is dropped.
   always_comb begin
      score_next_s = score_r;
      carry_s      = inc_pulse_s;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry_s) begin
            if (score_r[i*4 +: 4] == 4'd9) begin
               score_next_s[i*4 +: 4] = 4'd0;
               carry_s                = 1'b1;
            end else begin
               score_next_s[i*4 +: 4] = score_r[i*4 +: 4] + 4'd1;
               carry_s                = 1'b0;
            end
         end else begin
            score_next_s[i*4 +: 4] = score_r[i*4 +: 4];
         end
      end
   end

   // Score register only loads on a detected rising edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         score_r <= '0;
      end else if (inc_pulse_s) begin
         score_r <= score_next_s;
      end
   end

   seven_seg_mux #(
      .REFRESH_LOG2 (REFRESH_LOG2)
   ) u_seven_seg_mux (
      .clock          (clock),
      .reset          (reset),
      .score          (score_r),
      .anode_activate (anode_activate),
      .LED_out        (LED_out)
   );

endmodule

// File: tb/tb_clawgame_proc.sv
// Directed self-checking bench for clawgame_proc with REFRESH_LOG2 = 2.
module tb_clawgame_proc;

   logic       clock;
   logic       reset;
   logic       increment_score;
   logic [7:0] anode_activate;
   logic [7:0] LED_out;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   localparam logic [7:0] LED_0 = 8'hC0;
   localparam logic [7:0] LED_1 = 8'hF9;
   localparam logic [7:0] LED_5 = 8'h92;
   localparam logic [7:0] LED_9 = 8'h90;

   clawgame_proc #(
      .REFRESH_LOG2 (2),
      .NUM_DIGITS   (8)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .increment_score (increment_score),
      .anode_activate  (anode_activate),
      .LED_out         (LED_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) until digit d is selected, then checks anode and segments.
   task automatic check_digit(input string tag, input int d, input logic [7:0] exp_led);
      logic [7:0] exp_an;
      int n;
      exp_an = 8'hFF ^ (8'h01 << d);
      n = 0;
      while (anode_activate !== exp_an && n < 40) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_an"}, anode_activate, exp_an);
      check({tag, "_led"}, LED_out, exp_led);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         increment_score = 1'b1;
         repeat (2) @(negedge clock);
         increment_score = 1'b0;
         repeat (2) @(negedge clock);
      end
   endtask

   initial begin
      reset           = 1'b1;
      increment_score = 1'b0;

      // Reset held
      repeat (3) @(negedge clock);
      check("rst_an", anode_activate, 8'hFE);
      check("rst_led", LED_out, LED_0);

      // Release and follow one full scan, 4 cycles per digit
      reset = 1'b0;
      for (int k = 0; k < 32; k++) begin
         check($sformatf("scan%0d_an", k), anode_activate, 8'hFF ^ (8'h01 << (k / 4)));
         check($sformatf("scan%0d_led", k), LED_out, LED_0);
         @(negedge clock);
      end

      // Single held pulse: score becomes 1 exactly two edges after s1 samples it
      do_reset();
      increment_score = 1'b1;
      @(negedge clock);
      check("lat_e1", LED_out, LED_0);
      @(negedge clock);
      check("lat_e2", LED_out, LED_0);
      @(negedge clock);
      check("lat_e3_an", anode_activate, 8'hFE);
      check("lat_e3", LED_out, LED_1);
      repeat (2) @(negedge clock);
      increment_score = 1'b0;
      repeat (2) @(negedge clock);
      check_digit("one_d1", 1, LED_0);
      check_digit("one_d0", 0, LED_1);

      // Ten rising edges, toggling every 5 cycles
      do_reset();
      for (int i = 0; i < 10; i++) begin
         increment_score = 1'b1;
         repeat (5) @(negedge clock);
         increment_score = 1'b0;
         repeat (5) @(negedge clock);
      end
      check_digit("ten_d0", 0, LED_0);
      check_digit("ten_d1", 1, LED_1);
      check_digit("ten_d2", 2, LED_0);

      // 99 then 100: decimal carry through two digits
      do_reset();
      pulses(99);
      check_digit("n99_d0", 0, LED_9);
      check_digit("n99_d1", 1, LED_9);
      check_digit("n99_d2", 2, LED_0);
      pulses(1);
      check_digit("n100_d0", 0, LED_0);
      check_digit("n100_d1", 1, LED_0);
      check_digit("n100_d2", 2, LED_1);

      // Wraparound from 99999999
      do_reset();
      @(negedge clock);
      force dut.score_r = 32'h9999_9999;
      @(negedge clock);
      release dut.score_r;
      check_digit("pre_wrap_d7", 7, LED_9);
      check_digit("pre_wrap_d0", 0, LED_9);
      pulses(1);
      for (int d = 0; d < 8; d++) begin
         check_digit($sformatf("wrap_d%0d", d), d, LED_0);
      end

      // Asynchronous reset mid-scan with score 5
      do_reset();
      pulses(5);
      check_digit("five_d0", 0, LED_5);
      check_digit("five_d3", 3, LED_0);
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("async_an", anode_activate, 8'hFE);
      check("async_led", LED_out, LED_0);
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_digit("post_rst_d0", 0, LED_0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
